// File: rtl/spi_slave.sv
// spi_slave: SPI responder for the far end of the SPI master link.
//
// SCLK, CS_n and MOSI are oversampled by i_clk through SYNC_STAGES-deep
// synchronizers. Edges of the synchronized SCLK are classified as leading or
// trailing against the CPOL captured at CS_n assertion, and mapped to
// sample/drive edges by the captured CPHA. Words are MSB-first.
//
// Ports:
//   i_clk, i_rst        system clock, synchronous active-high reset
//   i_cpol, i_cpha      SPI mode, captured when CS_n asserts
//   i_sclk, i_cs_n      asynchronous SPI clock and chip select (active-low)
//   i_mosi              asynchronous master-out data
//   o_miso, o_miso_oe   slave-out data and its output enable (ACTIVE only)
//   i_tx_data/valid     write into the one-entry transmit holding buffer
//   o_tx_rdy            holding buffer empty
//   o_rx_data/valid     last received word, one-cycle update strobe
//   o_tx_underrun       one-cycle pulse when a word load finds the buffer empty
//   o_busy              frame in progress (ACTIVE)
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cpol,
  input  logic                  i_cpha,
  input  logic                  i_sclk,
  input  logic                  i_cs_n,
  input  logic                  i_mosi,
  output logic                  o_miso,
  output logic                  o_miso_oe,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_rdy,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_tx_underrun,
  output logic                  o_busy
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    WAIT_CS_HIGH,
    IDLE,
    ACTIVE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_d;
  logic                   cpol_q;
  logic                   cpha_q;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  rx_shift;
  logic [DATA_WIDTH-1:0]  tx_shift;
  logic [DATA_WIDTH-1:0]  tx_buf;
  logic                   buf_full;
  logic                   rx_done_p1;

  logic sclk_s;
  logic cs_s;
  logic mosi_s;
  logic lead_edge;
  logic trail_edge;
  logic sample_edge;
  logic drive_edge;
  logic tx_load;
  logic tx_shift_en;

  // Input synchronizers; sclk_d is the extra flop for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_s      = sclk_sync[SYNC_STAGES-1];
    cs_s        = cs_sync[SYNC_STAGES-1];
    mosi_s      = mosi_sync[SYNC_STAGES-1];
    lead_edge   = (sclk_d == cpol_q) && (sclk_s != cpol_q);
    trail_edge  = (sclk_d != cpol_q) && (sclk_s == cpol_q);
    sample_edge = cpha_q ? trail_edge : lead_edge;
    drive_edge  = cpha_q ? lead_edge : trail_edge;
    // A drive edge seen with the counter at 0 starts a new word in both
    // phases: for CPHA=1 it is the word's first leading edge, for CPHA=0 it
    // is the trailing edge right after the previous word's last sample.
    tx_load     = ((state == IDLE) && !cs_s && !i_cpha) ||
                  ((state == ACTIVE) && !cs_s && drive_edge && (bit_cnt == '0));
    tx_shift_en = (state == ACTIVE) && !cs_s && drive_edge && (bit_cnt != '0);
  end

  // Frame control, shift registers and transmit buffer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= WAIT_CS_HIGH;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      bit_cnt       <= '0;
      rx_shift      <= '0;
      tx_shift      <= '0;
      tx_buf        <= '0;
      buf_full      <= 1'b0;
      rx_done_p1    <= 1'b0;
      o_rx_data     <= '0;
      o_rx_valid    <= 1'b0;
      o_tx_underrun <= 1'b0;
    end else begin
      rx_done_p1    <= 1'b0;
      o_rx_valid    <= rx_done_p1;
      o_tx_underrun <= 1'b0;
      if (rx_done_p1) begin
        o_rx_data <= rx_shift;
      end

      case (state)
        WAIT_CS_HIGH: begin
          if (cs_s) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (!cs_s) begin
            state   <= ACTIVE;
            cpol_q  <= i_cpol;
            cpha_q  <= i_cpha;
            bit_cnt <= '0;
          end
        end
        ACTIVE: begin
          if (cs_s) begin
            state <= IDLE;
          end else if (sample_edge) begin
            rx_shift   <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
            bit_cnt    <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            rx_done_p1 <= (bit_cnt == LAST_BIT);
          end
        end
        default: state <= WAIT_CS_HIGH;
      endcase

      if (tx_load) begin
        tx_shift      <= buf_full ? tx_buf : '0;
        o_tx_underrun <= !buf_full;
        buf_full      <= 1'b0;
      end else if (tx_shift_en) begin
        tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
      end

      // Placed after the load so a same-cycle write refills the buffer
      if (i_tx_valid && !buf_full) begin
        tx_buf   <= i_tx_data;
        buf_full <= 1'b1;
      end
    end
  end

  assign o_busy    = (state == ACTIVE);
  assign o_miso_oe = (state == ACTIVE);
  assign o_miso    = (state == ACTIVE) ? tx_shift[DATA_WIDTH-1] : 1'b0;
  assign o_tx_rdy  = !buf_full;

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave acting as SPI master.
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpol;
  logic       cpha;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_rdy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       busy;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          rx_cnt   = 0;
  int          ur_cnt   = 0;
  logic [15:0] rx_hist  = 16'h0;

  always #5 clk = ~clk;

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cpol       (cpol),
    .i_cpha       (cpha),
    .i_sclk       (sclk),
    .i_cs_n       (cs_n),
    .i_mosi       (mosi),
    .o_miso       (miso),
    .o_miso_oe    (miso_oe),
    .i_tx_data    (tx_data),
    .i_tx_valid   (tx_valid),
    .o_tx_rdy     (tx_rdy),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .o_tx_underrun(tx_underrun),
    .o_busy       (busy)
  );

  // Pulse counters and history of received words
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt  = rx_cnt + 1;
      rx_hist = {rx_hist[7:0], rx_data};
    end
    if (tx_underrun) ur_cnt = ur_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic tx_write(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // One CS_n frame of nbits, MSB first; mi collects what the master samples
  task automatic frame(input logic p, input logic h, input int nbits,
                       input logic [15:0] mo, output logic [15:0] mi);
    mi   = 16'h0;
    cpol = p;
    cpha = h;
    sclk = p;
    repeat (4) @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (!h) begin
        mosi = mo[i];
        half();
        mi[i] = miso;
        sclk  = ~p;
        half();
        sclk = p;
      end else begin
        sclk = ~p;
        mosi = mo[i];
        half();
        mi[i] = miso;
        sclk  = p;
        half();
      end
    end
    half();
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_tx_rdy"},      32'(tx_rdy),      32'h1);
    chk({pfx, "_miso"},        32'(miso),        32'h0);
    chk({pfx, "_miso_oe"},     32'(miso_oe),     32'h0);
    chk({pfx, "_rx_valid"},    32'(rx_valid),    32'h0);
    chk({pfx, "_rx_data"},     32'(rx_data),     32'h0);
    chk({pfx, "_tx_underrun"}, 32'(tx_underrun), 32'h0);
    chk({pfx, "_busy"},        32'(busy),        32'h0);
  endtask

  initial begin
    logic [15:0] mi;
    int          r0;
    int          u0;
    logic        p;
    logic        h;

    rst      = 1'b1;
    cpol     = 1'b0;
    cpha     = 1'b0;
    sclk     = 1'b0;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Mode 0, preloaded 0xA5, master sends 0x3C
    chk("t1_rdy_empty", 32'(tx_rdy), 32'h1);
    tx_write(8'hA5);
    chk("t1_rdy_full", 32'(tx_rdy), 32'h0);
    r0 = rx_cnt;
    u0 = ur_cnt;
    fork
      frame(1'b0, 1'b0, 8, 16'h003C, mi);
      begin
        repeat (16) @(negedge clk);
        chk("t1_rdy_after_load", 32'(tx_rdy), 32'h1);
        chk("t1_no_underrun_at_load", 32'(ur_cnt - u0), 32'h0);
      end
    join
    chk("t1_miso", 32'(mi[7:0]), 32'hA5);
    chk("t1_rx_data", 32'(rx_data), 32'h3C);
    chk("t1_rx_pulses", 32'(rx_cnt - r0), 32'h1);

    // Modes 1..3 exchange 0x96 / 0x69
    for (int m = 1; m <= 3; m++) begin
      p = m[1];
      h = m[0];
      tx_write(8'h69);
      r0 = rx_cnt;
      u0 = ur_cnt;
      if (!h) begin
        // CPHA=0 reloads after the last bit, so keep a filler word ready
        fork
          frame(p, h, 8, 16'h0096, mi);
          begin
            repeat (18) @(negedge clk);
            tx_write(8'h00);
          end
        join
      end else begin
        frame(p, h, 8, 16'h0096, mi);
      end
      chk($sformatf("t2_m%0d_miso", m), 32'(mi[7:0]), 32'h69);
      chk($sformatf("t2_m%0d_rx_data", m), 32'(rx_data), 32'h96);
      chk($sformatf("t2_m%0d_rx_pulses", m), 32'(rx_cnt - r0), 32'h1);
      chk($sformatf("t2_m%0d_underruns", m), 32'(ur_cnt - u0), 32'h0);
    end

    // Two bytes in one frame, second tx word written during byte 1
    chk("t3_rdy_empty", 32'(tx_rdy), 32'h1);
    tx_write(8'hC3);
    r0 = rx_cnt;
    fork
      frame(1'b0, 1'b0, 16, 16'h1122, mi);
      begin
        repeat (20) @(negedge clk);
        chk("t3_rdy_midbyte", 32'(tx_rdy), 32'h1);
        tx_write(8'h5A);
      end
    join
    chk("t3_miso", 32'(mi), 32'hC35A);
    chk("t3_rx_pulses", 32'(rx_cnt - r0), 32'h2);
    chk("t3_rx_words", 32'(rx_hist), 32'h1122);

    // Empty buffer (mode 1: single load at the first leading edge)
    chk("t4_rdy_empty", 32'(tx_rdy), 32'h1);
    r0 = rx_cnt;
    u0 = ur_cnt;
    frame(1'b0, 1'b1, 8, 16'h005B, mi);
    chk("t4_underruns", 32'(ur_cnt - u0), 32'h1);
    chk("t4_miso", 32'(mi[7:0]), 32'h00);
    chk("t4_rx_data", 32'(rx_data), 32'h5B);
    chk("t4_rx_pulses", 32'(rx_cnt - r0), 32'h1);

    // Frame aborted after 5 SCLK edges, then a full 0xF0 frame
    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    r0   = rx_cnt;
    repeat (4) @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("t5_busy", 32'(busy), 32'h1);
    chk("t5_miso_oe", 32'(miso_oe), 32'h1);
    mosi = 1'b1; half(); sclk = 1'b1; half(); sclk = 1'b0;
    mosi = 1'b0; half(); sclk = 1'b1; half(); sclk = 1'b0;
    mosi = 1'b1; half(); sclk = 1'b1; half();
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("t5_abort_no_rx", 32'(rx_cnt - r0), 32'h0);
    chk("t5_abort_idle", 32'(busy), 32'h0);
    frame(1'b0, 1'b0, 8, 16'h00F0, mi);
    chk("t5_rx_data", 32'(rx_data), 32'hF0);
    chk("t5_rx_pulses", 32'(rx_cnt - r0), 32'h1);

    // Reset mid-frame with CS_n held low
    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    r0   = rx_cnt;
    repeat (4) @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b1; half(); sclk = 1'b1; half(); sclk = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("t6_rst");
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mosi = 1'b0; half(); sclk = 1'b1; half(); sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
    chk("t6_edges_ignored", 32'(rx_cnt - r0), 32'h0);
    chk("t6_not_busy", 32'(busy), 32'h0);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    tx_write(8'h3A);
    frame(1'b0, 1'b0, 8, 16'h00C5, mi);
    chk("t6_rx_data", 32'(rx_data), 32'hC5);
    chk("t6_miso", 32'(mi[7:0]), 32'h3A);
    chk("t6_rx_pulses", 32'(rx_cnt - r0), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
